snake_head_stepper: RTL
=======================

Name: snake_head_stepper

Overview:
- Consumes the debounced direction events produced by the keypad front end: a 2-bit direction plus a one-cycle valid strobe.
- Advances the snake head one grid cell per game tick, with wrap-around at the grid edges.
- Buffers up to two pending turns between ticks and rejects reversals.
- Feeds the body/renderer logic through `head_x`, `head_y` and the one-cycle `step_pulse`.

Parameters:
- GRID_W, 40, grid width in cells.
- GRID_H, 30, grid height in cells.
- X_W, 6, width of `head_x`.
- Y_W, 6, width of `head_y`.
- STEP_CYCLES, 5_000_000, sys_clk cycles per game tick. Minimum value is 2.
- CNT_W, 23, tick timer width. Must satisfy 2^CNT_W > STEP_CYCLES.
- START_X, 20, head column after start.
- START_Y, 15, head row after start.

Ports:
- sys_clk  in  1  system clock.
- sys_rst  in  1  asynchronous, active-high reset.
- start  in  1  level; begins or restarts a game.
- pause  in  1  level; freezes the game while high.
- dir_in  in  2  requested direction. Encodings come from the shared direction header: TOP 2'b00, DOWN 2'b01, LEFT 2'b10, RIGHT 2'b11.
- dir_valid  in  1  one-cycle strobe qualifying `dir_in`.
- head_x  out  X_W  head column.
- head_y  out  Y_W  head row; y=0 is the top row.
- cur_dir  out  2  committed direction of travel.
- step_pulse  out  1  one-cycle pulse on each head move.
- running  out  1  high while in RUN.
- game_over  out  1  wall-collision flag.

Behaviour:
- Reset values: state IDLE, head (START_X, START_Y), `cur_dir` TOP, queue empty, timer 0, `step_pulse`/`running`/`game_over` all 0.
- State machine:
  - IDLE: `start`=1 → RUN. On entry: timer←0, head←START, `cur_dir`←TOP, queue cleared, `game_over`←0.
  - RUN: `pause`=1 → PAUSED. `start` is ignored.
  - PAUSED: timer holds, `dir_valid` is ignored, `step_pulse`=0. `pause`=0 → RUN; the timer resumes from its held value.
  - OVER: exists only with the optional feature. `start`=1 → RUN with the same reload as IDLE.
- Tick timer, in RUN only:
  - Increments every cycle.
  - At timer==STEP_CYCLES-1: timer←0 and a step occurs.
  - The first step after start lands on the STEP_CYCLES-th rising edge after the edge that entered RUN.
- Step, all on one edge:
  - If the queue is non-empty, pop its head into `cur_dir`.
  - Move the head one cell in the (new) `cur_dir`: TOP y-1, DOWN y+1, LEFT x-1, RIGHT x+1.
  - Assert `step_pulse` for exactly that one cycle.
- Wrap-around:
  - x=GRID_W-1 moving RIGHT → 0; x=0 moving LEFT → GRID_W-1.
  - y=0 moving TOP → GRID_H-1; y=GRID_H-1 moving DOWN → 0.
  - Arithmetic never produces out-of-range coordinates.
- Turn queue: 2-entry FIFO, accepting `dir_valid` in RUN only.
  - Comparison reference = tail entry if the queue is non-empty, else `cur_dir`.
  - A request equal to the reference is dropped.
  - A request opposite to the reference (TOP/DOWN, LEFT/RIGHT) is dropped.
  - A request arriving when the queue is full is dropped.
  - Otherwise the request is pushed.
- Simultaneous `dir_valid` and step in the same cycle:
  - The pop happens first.
  - Acceptance is checked against the pre-pop tail (or `cur_dir` if the queue was empty).
  - The push lands after the popped entry leaves, so occupancy never exceeds 2.
- `running` = (state==RUN), registered.
- Asynchronous `sys_rst` mid-game returns the block to the reset values immediately. No step completes.

Optional Feature:
- SNAKE_WALL_DEATH_EN defined: a step that would wrap does not move the head. Instead:
  - State→OVER, `game_over`←1 on that edge.
  - `step_pulse` stays 0; head and `cur_dir` keep the pre-step values, and any queue entry is not popped.
  - `game_over` stays 1 until start or reset.
- Undefined: wrap as described above; OVER is unreachable; `game_over` is constant 0.

Test Plan (STEP_CYCLES=4, GRID_W=8, GRID_H=6, START=(4,3)):
- Reset, pulse `start`, no keys → `step_pulse` every 4 cycles; `head_y` goes 2,1,0,5 (wrap); `head_x` stays 4; `cur_dir` stays TOP.
- In RUN heading TOP, `dir_valid` with DOWN, then with TOP → both dropped; head keeps decrementing y.
- LEFT then DOWN strobed within one tick → next step moves to (3,y) with `cur_dir`=LEFT; the following step gives y+1 with `cur_dir`=DOWN.
- LEFT, DOWN, RIGHT strobed within one tick → RIGHT is dropped (queue full); the two steps follow LEFT then DOWN only.
- Pause 10 cycles mid-tick at timer=2 → no `step_pulse` during the pause; the first step comes 2 cycles after `pause` falls.
- SNAKE_WALL_DEATH_EN, head heading TOP from (4,3) → after 3 steps the head is at (4,0); the 4th tick gives `game_over`=1, head stays (4,0), no `step_pulse`, `running`=0. `start` → head (4,3), `game_over`=0.

Source files
------------

// File: rtl/snake_head_stepper.sv
// Snake head stepper: advances the head one cell per game tick, with a two-entry turn queue.
// Optional SNAKE_WALL_DEATH_EN: a step that would wrap ends the game instead of wrapping.
module snake_head_stepper #(
  parameter int GRID_W      = 40,
  parameter int GRID_H      = 30,
  parameter int X_W         = 6,
  parameter int Y_W         = 6,
  parameter int STEP_CYCLES = 5_000_000,
  parameter int CNT_W       = 23,
  parameter int START_X     = 20,
  parameter int START_Y     = 15
) (
  input  logic           sys_clk,
  input  logic           sys_rst,
  input  logic           start,
  input  logic           pause,
  input  logic [1:0]     dir_in,
  input  logic           dir_valid,
  output logic [X_W-1:0] head_x,
  output logic [Y_W-1:0] head_y,
  output logic [1:0]     cur_dir,
  output logic           step_pulse,
  output logic           running,
  output logic           game_over
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_PAUSED = 2'd2, S_OVER = 2'd3} state_t;

  localparam logic [1:0]       DIR_TOP   = 2'b00;
  localparam logic [1:0]       DIR_DOWN  = 2'b01;
  localparam logic [1:0]       DIR_LEFT  = 2'b10;
  localparam logic [1:0]       DIR_RIGHT = 2'b11;
  localparam logic [X_W-1:0]   X_MAX     = X_W'(GRID_W - 1);
  localparam logic [Y_W-1:0]   Y_MAX     = Y_W'(GRID_H - 1);
  localparam logic [X_W-1:0]   X_START   = X_W'(START_X);
  localparam logic [Y_W-1:0]   Y_START   = Y_W'(START_Y);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(STEP_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [X_W-1:0]   x_q, x_d, nx_s;
  logic [Y_W-1:0]   y_q, y_d, ny_s;
  logic [1:0]       dir_q, dir_d, q0_q, q0_d, q1_q, q1_d, cnt_q, cnt_d;
  logic [1:0]       new_dir_s, ref_dir_s;
  logic             pulse_q, pulse_d, run_q, run_d, over_q, over_d;
  logic             tick_s, wrap_s, die_s, accept_s;

  // State register and registered outputs
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= S_IDLE;
      timer_q <= {CNT_W{1'b0}};
      x_q     <= X_START;
      y_q     <= Y_START;
      dir_q   <= DIR_TOP;
      q0_q    <= DIR_TOP;
      q1_q    <= DIR_TOP;
      cnt_q   <= 2'd0;
      pulse_q <= 1'b0;
      run_q   <= 1'b0;
      over_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      x_q     <= x_d;
      y_q     <= y_d;
      dir_q   <= dir_d;
      q0_q    <= q0_d;
      q1_q    <= q1_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
      run_q   <= run_d;
      over_q  <= over_d;
    end
  end

  // Next-state: tick timer, step/wrap, turn queue pop-then-push
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    x_d     = x_q;
    y_d     = y_q;
    dir_d   = dir_q;
    q0_d    = q0_q;
    q1_d    = q1_q;
    cnt_d   = cnt_q;
    pulse_d = 1'b0;
    over_d  = over_q;
    nx_s    = x_q;
    ny_s    = y_q;
    wrap_s  = 1'b0;

    tick_s    = (timer_q == CNT_LAST);
    new_dir_s = (cnt_q != 2'd0) ? q0_q : dir_q;
    // With one entry the tail is q0, which new_dir_s already selects.
    ref_dir_s = (cnt_q == 2'd2) ? q1_q : new_dir_s;
    // Opposite directions differ only in bit 0.
    accept_s  = dir_valid && (dir_in != ref_dir_s) && ((dir_in ^ ref_dir_s) != 2'b01)
                && (cnt_q != 2'd2);

    case (new_dir_s)
      DIR_TOP: begin
        wrap_s = (y_q == {Y_W{1'b0}});
        ny_s   = wrap_s ? Y_MAX : y_q - Y_W'(1);
      end
      DIR_DOWN: begin
        wrap_s = (y_q == Y_MAX);
        ny_s   = wrap_s ? {Y_W{1'b0}} : y_q + Y_W'(1);
      end
      DIR_LEFT: begin
        wrap_s = (x_q == {X_W{1'b0}});
        nx_s   = wrap_s ? X_MAX : x_q - X_W'(1);
      end
      DIR_RIGHT: begin
        wrap_s = (x_q == X_MAX);
        nx_s   = wrap_s ? {X_W{1'b0}} : x_q + X_W'(1);
      end
      default: wrap_s = 1'b0;
    endcase

`ifdef SNAKE_WALL_DEATH_EN
    die_s = tick_s && wrap_s;
`else
    die_s = 1'b0;
`endif

    case (state_q)
      S_IDLE, S_OVER: begin
        if (start) begin
          state_d = S_RUN;
          timer_d = {CNT_W{1'b0}};
          x_d     = X_START;
          y_d     = Y_START;
          dir_d   = DIR_TOP;
          cnt_d   = 2'd0;
          over_d  = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      S_RUN: begin
        timer_d = tick_s ? {CNT_W{1'b0}} : timer_q + CNT_W'(1);
        if (die_s) begin
          over_d = 1'b1;
        end else if (tick_s) begin
          dir_d   = new_dir_s;
          x_d     = nx_s;
          y_d     = ny_s;
          pulse_d = 1'b1;
          if (cnt_q != 2'd0) begin
            q0_d  = q1_q;
            cnt_d = cnt_q - 2'd1;
          end else begin
            cnt_d = cnt_q;
          end
        end else begin
          pulse_d = 1'b0;
        end
        if (accept_s) begin
          if (cnt_d == 2'd0) begin
            q0_d = dir_in;
          end else begin
            q1_d = dir_in;
          end
          cnt_d = cnt_d + 2'd1;
        end else begin
          cnt_d = cnt_d;
        end
        if (die_s) begin
          state_d = S_OVER;
        end else if (pause) begin
          state_d = S_PAUSED;
        end else begin
          state_d = S_RUN;
        end
      end
      S_PAUSED: state_d = pause ? S_PAUSED : S_RUN;
      default:  state_d = S_IDLE;
    endcase

    run_d = (state_d == S_RUN);
  end

  assign head_x     = x_q;
  assign head_y     = y_q;
  assign cur_dir    = dir_q;
  assign step_pulse = pulse_q;
  assign running    = run_q;
  assign game_over  = over_q;

endmodule
